periph_apb_arbiter: RTL and testbench
=====================================

// Module: periph_apb_arbiter
// PURPOSE
//   Round-robin arbiter and APB master sequencer that shares one APB peripheral slave (e.g. UART
//   register file) between NumReq simple request/response masters (bridge, debug loader, ...).
//   Serialises one transfer at a time through APB SETUP/ACCESS phases.
//   A timeout guard terminates hung transfers with an error response.
// PARAMETERS
//   NumReq        2   number of requesters (>=2)
//   AddrWidth     32  APB/requester address width
//   DataWidth     32  APB/requester data width
//   TimeoutCycles 64  max ACCESS cycles before forced error completion; 0 = no timeout
// PORTS
//   clk_i      in  1                 clock
//   rst_i      in  1                 reset, synchronous, active-high
//   req_i      in  NumReq            per-requester request; held with payload until gnt_o
//   we_i       in  NumReq            per-requester write enable
//   addr_i     in  NumReq*AddrWidth  per-requester address, requester k at [k*AddrWidth +: AddrWidth]
//   wdata_i    in  NumReq*DataWidth  per-requester write data, same packing
//   gnt_o      out NumReq            one-hot grant pulse, request and payload accepted
//   rvalid_o   out NumReq            one-hot response pulse to the owning requester
//   rdata_o    out DataWidth         read data, valid with rvalid_o (shared)
//   err_o      out 1                 error flag, valid with rvalid_o (shared)
//   psel_o     out 1                 APB select
//   penable_o  out 1                 APB enable
//   pwrite_o   out 1                 APB write
//   paddr_o    out AddrWidth         APB address
//   pwdata_o   out DataWidth         APB write data
//   prdata_i   in  DataWidth         APB read data
//   pready_i   in  1                 APB ready
//   pslverr_i  in  1                 APB slave error
// BEHAVIOUR
//   Reset: state IDLE, rr pointer 0; all outputs 0 (psel/penable/pwrite/paddr/pwdata/gnt/rvalid/rdata/err).
//   FSM: IDLE -> SETUP -> ACCESS -> IDLE. One outstanding transfer max.
//   IDLE: if |req_i, winner = first k with req_i[k], searching ptr, ptr+1, ... mod NumReq.
//     gnt_o[winner] asserted combinationally this cycle. Latch we/addr/wdata/owner into
//     registers. Set ptr <= (winner+1) mod NumReq. Go SETUP. No req: stay IDLE, gnt_o=0.
//   SETUP: psel=1, penable=0, pwrite/paddr/pwdata = latched values. Always go ACCESS next.
//   ACCESS: psel=1, penable=1, signals held stable. Timeout counter increments each ACCESS cycle.
//     pready_i=1: go IDLE. Next cycle: rvalid_o[owner]=1, rdata_o=prdata_i (0 for writes),
//       err_o=pslverr_i.
//     Timeout: counter == TimeoutCycles-1 and pready_i=0. Go IDLE. Next cycle: rvalid_o[owner]=1,
//       err_o=1, rdata_o=32'hDEADBEEF (zero-extended/truncated to DataWidth).
//   pready_i and timeout in the same cycle: pready wins, normal completion.
//   Counter: width $clog2(TimeoutCycles+1). Cleared on entering SETUP.
//   psel/penable drop to 0 in the cycle after completion.
//   rvalid_o, rdata_o, err_o are registered one-cycle pulses. rdata/err return to 0 when rvalid=0.
//   The response cycle coincides with IDLE, so a new grant may issue in that same cycle.
//   Latency: grant at N, SETUP N+1, ACCESS N+2; with pready at N+2, response at N+3.
//     Minimum 4 cycles per transfer. Back-to-back throughput: 1 transfer per 3 cycles.
//   Requests arriving outside IDLE are not granted. Requesters keep req_i high until gnt_o.
//   Requester dropping req_i before grant: legal, no effect.
//   Requester dropping req_i after grant: response still delivered.
//   Reset mid-transfer: next cycle IDLE, psel=penable=0, pending response discarded, ptr=0.
//   Ignore pready_i/pslverr_i/prdata_i outside ACCESS.
// TESTING
//   Single read: req0 addr 0x10 -> gnt0 at N; psel N+1..N+2; penable N+2; prdata 0x5A with
//     pready at N+2 -> rvalid0 at N+3, rdata 0x5A, err 0.
//   Contention: req0 and req1 held high for 4 transfers -> grants alternate 0,1,0,1.
//     Each rvalid goes to the matching owner.
//   Wait states: write, pready low for 3 ACCESS cycles -> paddr/pwdata/pwrite stable throughout.
//     rvalid 1 cycle after pready, err=pslverr.
//   Timeout: TimeoutCycles=4, pready stuck at 0 -> penable high for 4 cycles, then psel drops.
//     rvalid with err=1, rdata 0xDEADBEEF.
//   Reset at ACCESS: rst_i=1 for 1 cycle -> psel/penable 0, no rvalid.
//     Next request goes to requester 0 first.
//   Fairness: req1 held, req0 pulsed every cycle -> req1 granted within 2 transfers.

Source files
------------

// File: rtl/periph_apb_arbiter.sv
// periph_apb_arbiter
//   Round-robin arbiter plus APB master sequencer. NumReq request/response
//   masters share one APB slave; one transfer is in flight at a time and is
//   walked through SETUP and ACCESS. A hung ACCESS phase is terminated after
//   TimeoutCycles cycles with an error response (TimeoutCycles=0 disables).
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i/we_i              per-requester request and write enable
//   addr_i/wdata_i          per-requester payload, requester k at [k*W +: W]
//   gnt_o                   one-hot combinational grant (IDLE only)
//   rvalid_o/rdata_o/err_o  registered one-cycle response to the owner
//   psel_o..pwdata_o        APB master outputs (registered)
//   prdata_i/pready_i/pslverr_i  APB slave returns, used in ACCESS only
module periph_apb_arbiter #(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              we_i,
  input  logic [NumReq*AddrWidth-1:0]    addr_i,
  input  logic [NumReq*DataWidth-1:0]    wdata_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           err_o,
  output logic                           psel_o,
  output logic                           penable_o,
  output logic                           pwrite_o,
  output logic [AddrWidth-1:0]           paddr_o,
  output logic [DataWidth-1:0]           pwdata_o,
  input  logic [DataWidth-1:0]           prdata_i,
  input  logic                           pready_i,
  input  logic                           pslverr_i
);

  localparam int PtrW = $clog2(NumReq);
  // Wide enough to hold TimeoutCycles; kept at 1 bit when the guard is off.
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [DataWidth-1:0] ToData = DataWidth'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                              state;
  logic [PtrW-1:0]                     ptr;
  logic [PtrW-1:0]                     owner;
  logic [CntW-1:0]                     cnt;
  logic [NumReq-1:0][AddrWidth-1:0]    addr_v;
  logic [NumReq-1:0][DataWidth-1:0]    wdata_v;
  logic                                any_req;
  logic [PtrW-1:0]                     win;
  logic [PtrW-1:0]                     ptr_nxt;
  logic                                to_hit;

  // Packed 2-D view matches the flat k*W packing directly.
  assign addr_v  = addr_i;
  assign wdata_v = wdata_i;

  // Round-robin search starting at ptr.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!any_req && req_i[(int'(ptr) + i) % NumReq]) begin
        any_req = 1'b1;
        win     = PtrW'((int'(ptr) + i) % NumReq);
      end
    end
  end

  assign ptr_nxt = (win == PtrW'(NumReq - 1)) ? '0 : win + 1'b1;
  assign to_hit  = (TimeoutCycles > 0) && (cnt == CntLast);

  // Grant is combinational; suppressed during reset so nothing is accepted
  // that the FSM would not latch.
  always_comb begin
    gnt_o = '0;
    if (state == IDLE && any_req && !rst_i) gnt_o[win] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      rvalid_o  <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses, zero otherwise.
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= win;
            pwrite_o <= we_i[win];
            paddr_o  <= addr_v[win];
            pwdata_o <= wdata_v[win];
            ptr      <= ptr_nxt;
            cnt      <= '0;
            psel_o   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          // pready takes priority over a coincident timeout.
          if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= NumReq'(1) << owner;
            rdata_o   <= pwrite_o ? '0 : prdata_i;
            err_o     <= pslverr_i;
            state     <= IDLE;
          end else if (to_hit) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= NumReq'(1) << owner;
            rdata_o   <= ToData;
            err_o     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_apb_arbiter.sv
module tb_periph_apb_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]         req = '0;
  logic [NR-1:0]         we  = '0;
  logic [NR-1:0][AW-1:0] addr  = '0;
  logic [NR-1:0][DW-1:0] wdata = '0;
  logic [NR-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic err, psel, penable, pwrite, pready, pslverr;

  int wait_n  = 0;
  int acc_cnt = 0;
  int checks  = 0;
  int errors  = 0;

  typedef struct {
    int            owner;
    logic [DW-1:0] rdata;
    logic          err;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   glog[$];

  periph_apb_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  // Slave model: ready after wait_n stalled ACCESS cycles, data/err from address.
  assign pready  = psel && penable && (acc_cnt == wait_n);
  assign prdata  = paddr ^ 32'h4A;
  assign pslverr = paddr[12];
  always @(posedge clk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on grant, pop on response.
  always @(negedge clk) begin
    exp_t e;
    logic [NR-1:0] oh;
    if (rst) sb.delete();
    else begin
      if (rvalid != '0) begin
        if (sb.size() == 0) chk("rvalid_unexpected", rvalid, 0);
        else begin
          e  = sb.pop_front();
          oh = '0;
          oh[e.owner] = 1'b1;
          chk("rsp_owner", rvalid, oh);
          chk("rsp_rdata", rdata, e.rdata);
          chk("rsp_err", err, e.err);
        end
      end else if (rdata != '0 || err) chk("rsp_idle_zero", {rdata, err}, 0);
      if (gnt != '0) begin
        chk("gnt_onehot", $onehot(gnt), 1);
        e.owner = 0;
        for (int i = 0; i < NR; i++) if (gnt[i]) e.owner = i;
        e.we    = we[e.owner];
        e.addr  = addr[e.owner];
        e.wdata = wdata[e.owner];
        if (wait_n >= TO) begin
          e.err = 1'b1; e.rdata = 32'hDEADBEEF;
        end else begin
          e.err = e.addr[12]; e.rdata = e.we ? '0 : (e.addr ^ 32'h4A);
        end
        sb.push_back(e);
        glog.push_back(e.owner);
        cur = e;
      end
      if (psel && !penable) begin
        chk("setup_paddr", paddr, cur.addr);
        chk("setup_pwrite", pwrite, cur.we);
        chk("setup_pwdata", pwdata, cur.wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input int k);
    bit ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (gnt[k]) begin ok = 1; break; end
    end
    if (!ok) chk("gnt_wait_expired", 0, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !psel) break;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    step(); step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_psel", psel, 0);     chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0); chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0); chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0); chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);

    // Single read, cycle-exact latency
    step(); wait_n = 0; we[0] = 0; addr[0] = 32'h10; req[0] = 1;
    @(negedge clk); chk("rd_gnt_N", gnt, 2'b01);
    step(); req[0] = 0;
    @(negedge clk); chk("rd_psel_N1", psel, 1); chk("rd_pen_N1", penable, 0);
    step();
    @(negedge clk); chk("rd_psel_N2", psel, 1); chk("rd_pen_N2", penable, 1);
    step();
    @(negedge clk); chk("rd_rvalid_N3", rvalid, 2'b01); chk("rd_rdata", rdata, 32'h5A);
    chk("rd_err", err, 0); chk("rd_psel_N3", psel, 0);
    drain();

    // Contention: ptr is 1 after the read from 0, so order is 1,0,1,0
    step(); glog.delete();
    addr[0] = 32'h20; we[0] = 0; addr[1] = 32'h1004; we[1] = 1; wdata[1] = 32'h12345678;
    req = 2'b11;
    for (int c = 0; c < 60 && glog.size() < 4; c++) begin @(negedge clk); #1; end
    step(); req = '0;
    chk("cont_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("cont_order", glog[i], (i % 2 == 0) ? 1 : 0);
    drain();

    // Wait states on a write; pready on the last allowed ACCESS cycle wins
    step(); wait_n = 3; we[0] = 1; addr[0] = 32'h1030; wdata[0] = 32'hCAFE0001; req[0] = 1;
    wait_gnt(0); step(); req[0] = 0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (psel && penable) begin
        n++;
        chk("ws_paddr", paddr, 32'h1030); chk("ws_pwdata", pwdata, 32'hCAFE0001);
        chk("ws_pwrite", pwrite, 1);
        if (pready) begin
          step(); @(negedge clk);
          chk("ws_rvalid", rvalid, 2'b01); chk("ws_err", err, 1);
          break;
        end
      end
    end
    chk("ws_access_cycles", n, 4);
    drain();

    // Timeout with pready stuck low
    step(); wait_n = 100; we[0] = 0; addr[0] = 32'h44; req[0] = 1;
    wait_gnt(0); step(); req[0] = 0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (penable) n++;
      else if (n > 0) break;
    end
    chk("to_pen_cycles", n, 4); chk("to_psel", psel, 0);
    chk("to_rvalid", rvalid, 2'b01); chk("to_err", err, 1);
    chk("to_rdata", rdata, 32'hDEADBEEF);
    drain();

    // Reset during ACCESS: no response, pointer back to 0
    step(); wait_n = 100; addr[0] = 32'h50; req[0] = 1;
    wait_gnt(0); step(); req[0] = 0;
    for (int c = 0; c < 10 && !penable; c++) @(negedge clk);
    step(); rst = 1;
    @(negedge clk);
    step(); rst = 0;
    @(negedge clk);
    chk("rsta_psel", psel, 0); chk("rsta_penable", penable, 0); chk("rsta_rvalid", rvalid, 0);
    wait_n = 0;
    repeat (3) begin @(negedge clk); chk("rsta_no_rvalid", rvalid, 0); end
    step(); glog.delete(); addr[0] = 32'h60; addr[1] = 32'h64; we = '0; req = 2'b11;
    @(negedge clk); chk("rsta_ptr0_gnt", gnt, 2'b01);
    step(); req = '0;
    drain();

    // Fairness: req1 held, req0 toggling every cycle
    step(); glog.delete(); wait_n = 0;
    addr[1] = 32'h70; addr[0] = 32'h74; we = '0; req[1] = 1;
    for (int c = 0; c < 40; c++) begin
      req[0] = ~req[0];
      @(negedge clk); #1;
      n = -1;
      foreach (glog[i]) if (glog[i] == 1 && n < 0) n = i;
      if (n >= 0) break;
      step();
    end
    step(); req = '0;
    chk("fair_req1_seen", (n >= 0), 1);
    chk("fair_within2", (n >= 0 && n < 2), 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
